// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared types and helpers for the PS/2 host port.
//   ps2_state_t     : host port FSM states
//   PS2_FRAME_BITS  : bits per PS/2 frame (start, 8 data, parity, stop)
//   odd_parity()    : parity bit that makes the 9-bit {parity, data} group odd
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_TX_INH,
    ST_TX_RTS,
    ST_TX_DATA,
    ST_TX_ACK
  } ps2_state_t;

  localparam int PS2_FRAME_BITS = 11;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo -- synchronous byte FIFO for received PS/2 bytes.
// All state advances only when en is high.
//   clk, reset : system clock, asynchronous active-high reset
//   en         : clock enable
//   push/wdata : write request and byte; accepted when not full, or when full
//                and a pop happens on the same tick
//   pop        : remove head byte; ignored when empty
//   rdata      : registered head byte
//   full       : FIFO holds 2**AW bytes
//   level      : number of bytes held
module ps2_rx_fifo #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic          full,
  output logic [AW:0]   level
);

  localparam int DEPTH = 1 << AW;

  logic [7:0]    mem [0:DEPTH-1];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_ptr_next;
  logic [AW:0]   count_reg;
  logic [7:0]    rdata_reg;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;
  logic          bypass;

  assign empty       = (count_reg == '0);
  assign full        = (count_reg == (AW+1)'(DEPTH));
  assign pop_ok      = en & pop & ~empty;
  assign push_ok     = en & push & (~full | pop_ok);
  assign rd_ptr_next = pop_ok ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
  // A byte written into a FIFO that is (or is about to become) empty lands at
  // the next head address; the RAM read cannot see it yet, so forward it.
  assign bypass      = push_ok && (wr_ptr_reg == rd_ptr_next);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      rdata_reg  <= '0;
    end else if (en) begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      rd_ptr_reg <= rd_ptr_next;
      if (push_ok && !pop_ok) begin
        count_reg <= count_reg + 1'b1;
      end else if (!push_ok && pop_ok) begin
        count_reg <= count_reg - 1'b1;
      end
      rdata_reg <= bypass ? wdata : mem[rd_ptr_next];
    end
  end

  assign rdata = rdata_reg;
  assign level = count_reg;

endmodule

// File: rtl/ps2_host_port.sv
// ps2_host_port -- PS/2 host transceiver, one instance per physical port.
// Receives device frames into an RX FIFO and sends host-to-device command
// bytes (inhibit, request-to-send, bit shifting, ACK check).
//   clk, reset        : system clock, asynchronous active-high reset
//   clk7_en           : 7MHz enable; every register advances only when high
//   ps2clk_i/ps2dat_i : raw pad inputs
//   ps2clk_o/ps2dat_o : open-drain controls, 0 = drive low, 1 = release
//   tx_data/valid/ready : command byte handshake (ready only in IDLE)
//   rx_data/valid/ready : FIFO head byte handshake, rx_level = bytes held
//   err_*             : one-tick error pulses (parity/stop, ACK, watchdog, overflow)
module ps2_host_port
  import ps2_pkg::*;
#(
  parameter int FIFO_AW     = 3,
  parameter int FILT_LEN    = 4,
  parameter int INHIBIT_CYC = 710,
  parameter int TIMEOUT_CYC = 14180
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk7_en,
  input  logic               ps2clk_i,
  input  logic               ps2dat_i,
  output logic               ps2clk_o,
  output logic               ps2dat_o,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [FIFO_AW:0]   rx_level,
  output logic               err_parity,
  output logic               err_ack,
  output logic               err_timeout,
  output logic               err_overflow
);

  localparam int FW      = $clog2(FILT_LEN + 1);
  localparam int TMR_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] INH_LAST = TMR_W'(INHIBIT_CYC - 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       LAST_BIT = 4'(PS2_FRAME_BITS - 2);

  // input conditioning
  logic [1:0]    clk_sync_reg;
  logic [1:0]    dat_sync_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          clk_filt_reg;
  logic          clk_filt_d_reg;
  logic          dat_s;
  logic          clk_fall;
  logic          clk_edge;

  // protocol state
  ps2_state_t       state_reg, state_next;
  logic [3:0]       bit_cnt_reg, bit_cnt_next;
  logic [9:0]       rx_shift_reg, rx_shift_next;
  logic [8:0]       tx_shift_reg, tx_shift_next;
  logic [TMR_W-1:0] tmr_reg, tmr_next;
  logic             ack_seen_reg, ack_seen_next;
  logic             clk_o_reg, clk_o_next;
  logic             dat_o_reg, dat_o_next;
  logic             started_reg;
  logic             err_parity_reg, err_parity_next;
  logic             err_ack_reg, err_ack_next;
  logic             err_timeout_reg, err_timeout_next;
  logic             err_overflow_reg, err_overflow_next;

  logic [9:0]       rx_word;
  logic             rx_push;
  logic             wd_active;
  logic             wd_timeout;
  logic             fifo_full;

  assign dat_s    = dat_sync_reg[1];
  assign clk_fall = clk_filt_d_reg & ~clk_filt_reg;
  assign clk_edge = clk_filt_d_reg ^ clk_filt_reg;
  // Frame as it will look once the bit on the line now is shifted in:
  // [7:0] data, [8] parity, [9] stop.
  assign rx_word  = {dat_s, rx_shift_reg[9:1]};
  assign wd_active = (state_reg == ST_RX) || (state_reg == ST_TX_RTS) ||
                     (state_reg == ST_TX_DATA) || (state_reg == ST_TX_ACK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_reg   <= 2'b11;
      dat_sync_reg   <= 2'b11;
      filt_cnt_reg   <= '0;
      clk_filt_reg   <= 1'b1;
      clk_filt_d_reg <= 1'b1;
    end else if (clk7_en) begin
      clk_sync_reg   <= {clk_sync_reg[0], ps2clk_i};
      dat_sync_reg   <= {dat_sync_reg[0], ps2dat_i};
      clk_filt_d_reg <= clk_filt_reg;
      // Accept a new clock level only after FILT_LEN consecutive samples of it.
      if (clk_sync_reg[1] == clk_filt_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FW'(FILT_LEN - 1)) begin
        clk_filt_reg <= clk_sync_reg[1];
        filt_cnt_reg <= '0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next        = state_reg;
    bit_cnt_next      = bit_cnt_reg;
    rx_shift_next     = rx_shift_reg;
    tx_shift_next     = tx_shift_reg;
    tmr_next          = tmr_reg;
    ack_seen_next     = ack_seen_reg;
    clk_o_next        = clk_o_reg;
    dat_o_next        = dat_o_reg;
    rx_push           = 1'b0;
    err_parity_next   = 1'b0;
    err_ack_next      = 1'b0;
    err_timeout_next  = 1'b0;
    wd_timeout        = 1'b0;

    // Shared timer: watchdog in the line-clocked states, inhibit length in TX_INH.
    if (wd_active) begin
      if (clk_edge) begin
        tmr_next = '0;
      end else if (tmr_reg == TMO_LAST) begin
        wd_timeout = 1'b1;
      end else begin
        tmr_next = tmr_reg + 1'b1;
      end
    end

    case (state_reg)
      ST_IDLE: begin
        clk_o_next    = 1'b1;
        dat_o_next    = 1'b1;
        tmr_next      = '0;
        bit_cnt_next  = '0;
        ack_seen_next = 1'b0;
        if (tx_valid && started_reg) begin
          state_next    = ST_TX_INH;
          clk_o_next    = 1'b0;
          tx_shift_next = {odd_parity(tx_data), tx_data};
        end else if (clk_fall && !dat_s) begin
          state_next = ST_RX;
        end
      end
      ST_RX: begin
        if (clk_fall) begin
          rx_shift_next = rx_word;
          bit_cnt_next  = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == LAST_BIT) begin
            if ((^rx_word[8:0]) && rx_word[9]) begin
              rx_push = 1'b1;
            end else begin
              err_parity_next = 1'b1;
            end
            state_next = ST_IDLE;
          end
        end
      end
      ST_TX_INH: begin
        clk_o_next = 1'b0;
        if (tmr_reg == INH_LAST) begin
          dat_o_next = 1'b0;
          tmr_next   = '0;
          state_next = ST_TX_RTS;
        end else begin
          tmr_next = tmr_reg + 1'b1;
        end
      end
      ST_TX_RTS: begin
        clk_o_next = 1'b1;
        state_next = ST_TX_DATA;
      end
      ST_TX_DATA: begin
        // The device samples on its rising edge, so each new bit goes out
        // right after a falling edge; the tenth edge releases data as stop.
        if (clk_fall) begin
          if (bit_cnt_reg == LAST_BIT) begin
            dat_o_next = 1'b1;
            state_next = ST_TX_ACK;
          end else begin
            dat_o_next    = tx_shift_reg[0];
            tx_shift_next = {1'b0, tx_shift_reg[8:1]};
            bit_cnt_next  = bit_cnt_reg + 4'd1;
          end
        end
      end
      ST_TX_ACK: begin
        if (!ack_seen_reg) begin
          if (clk_fall) begin
            ack_seen_next = 1'b1;
            err_ack_next  = dat_s;
          end
        end else if (clk_filt_reg && dat_s) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (wd_timeout) begin
      state_next       = ST_IDLE;
      clk_o_next       = 1'b1;
      dat_o_next       = 1'b1;
      tmr_next         = '0;
      err_timeout_next = 1'b1;
    end
  end

  // A good byte with a full FIFO is only lost if no pop frees a slot this tick.
  assign err_overflow_next = rx_push & fifo_full & ~(rx_ready & rx_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      bit_cnt_reg      <= '0;
      rx_shift_reg     <= '0;
      tx_shift_reg     <= '0;
      tmr_reg          <= '0;
      ack_seen_reg     <= 1'b0;
      clk_o_reg        <= 1'b1;
      dat_o_reg        <= 1'b1;
      started_reg      <= 1'b0;
      err_parity_reg   <= 1'b0;
      err_ack_reg      <= 1'b0;
      err_timeout_reg  <= 1'b0;
      err_overflow_reg <= 1'b0;
    end else if (clk7_en) begin
      state_reg        <= state_next;
      bit_cnt_reg      <= bit_cnt_next;
      rx_shift_reg     <= rx_shift_next;
      tx_shift_reg     <= tx_shift_next;
      tmr_reg          <= tmr_next;
      ack_seen_reg     <= ack_seen_next;
      clk_o_reg        <= clk_o_next;
      dat_o_reg        <= dat_o_next;
      started_reg      <= 1'b1;
      err_parity_reg   <= err_parity_next;
      err_ack_reg      <= err_ack_next;
      err_timeout_reg  <= err_timeout_next;
      err_overflow_reg <= err_overflow_next;
    end
  end

  ps2_rx_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .en    (clk7_en),
    .push  (rx_push),
    .wdata (rx_word[7:0]),
    .pop   (rx_ready),
    .rdata (rx_data),
    .full  (fifo_full),
    .level (rx_level)
  );

  assign rx_valid     = (rx_level != '0);
  assign tx_ready     = started_reg && (state_reg == ST_IDLE);
  assign ps2clk_o     = clk_o_reg;
  assign ps2dat_o     = dat_o_reg;
  assign err_parity   = err_parity_reg;
  assign err_ack      = err_ack_reg;
  assign err_timeout  = err_timeout_reg;
  assign err_overflow = err_overflow_reg;

endmodule
